timer0_io_read_port: RTL and testbench
======================================

# timer0_io_read_port

CPU-facing register port for the 8-bit Timer0 block. It owns the TIFR flag bits (TOV0, OCF0) and the TIMSK enable bits (TOIE0, OCIE0). It sets the flags from hardware event pulses and clears them on a write-one or on an interrupt acknowledge. It also returns registered read data for the Timer0 I/O addresses to the CPU data bus. It is the read/status side of the enabled timer registers (TCNT0, OCR0, TCCR0), which remain the register-holding flip-flops elsewhere in Timer0.

## Interface
Parameters:
- TCNT_ADDR, 6'h32, I/O address of TCNT0
- TCCR_ADDR, 6'h33, I/O address of TCCR0
- TIFR_ADDR, 6'h38, I/O address of TIFR
- TIMSK_ADDR, 6'h39, I/O address of TIMSK
- OCR_ADDR, 6'h3C, I/O address of OCR0

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- clr  in  1  reset, synchronous, active-high
- io_addr  in  6  I/O address
- io_rd  in  1  read strobe, one cycle
- io_wr  in  1  write strobe, one cycle
- io_wdata  in  8  write data
- io_rdata  out  8  registered read data; 0 when not driving
- io_rvalid  out  1  read data valid, one cycle
- tcnt_in, ocr_in, tccr_in  in  8 each  current TCNT0/OCR0/TCCR0 values
- tov_evt, ocf_evt  in  1 each  overflow and compare-match event pulses
- irq_ack_tov, irq_ack_ocf  in  1 each  interrupt-serviced acknowledges
- irq_tov, irq_ocf  out  1 each  interrupt requests

## Operation
Registers and bit positions:
- TIFR bit0 = TOV0, bit1 = OCF0. TIMSK bit0 = TOIE0, bit1 = OCIE0. All other bits read as 0.

Flag update, per flag, priority highest first:
1. Reset: flag clears to 0.
2. Event pulse: flag sets to 1. An event wins over a simultaneous clear.
3. Clear: flag clears to 0 on either of:
   - io_wr to TIFR_ADDR with a 1 in the flag's bit position.
   - The matching irq_ack_*. This path exists only when the configuration macro is defined.
4. Otherwise the flag holds its value.

TIMSK:
- io_wr to TIMSK_ADDR loads bits [1:0]. Bits [7:2] are ignored.

Interrupt requests:
- irq_tov = TOV0 & TOIE0; irq_ocf = OCF0 & OCIE0. Both are combinational from registered state.

Reads:
- io_rd with io_addr matching one of the five addresses: the next cycle has io_rvalid=1 and io_rdata = that register's value sampled at the io_rd edge.
- A non-matching address or no io_rd: io_rvalid=0 and io_rdata=8'h00, so the output can be OR-combined on the data bus.
- Writes to TCNT/OCR/TCCR addresses are ignored here.

## Timing
- Reset values: io_rdata=0, io_rvalid=0, flags=0, TIMSK=0, irq_*=0.
- Read latency: 1 cycle. A read in the same cycle as a write or event to the same register returns the pre-update value.
- Flag set latency: an event in cycle N makes the flag and irq visible in cycle N+1.
- Back-to-back io_rd every cycle is supported; each read gets its own io_rvalid.
- io_rd and io_wr asserted together are both honoured.
- Reset asserted mid-read drops that read: io_rvalid=0 in the next cycle.

## Configuration
- TIMER0_IRQ_ACK_CLR_EN defined: irq_ack_tov and irq_ack_ocf clear their flags, giving AVR hardware-clear-on-vector behaviour.
- Not defined: the ack inputs are ignored, and flags clear only by write-one or reset.

## Structure
- The shared package timer0_pkg holds:
  - the default I/O address constants;
  - the bit-index constants TOV0_BIT, OCF0_BIT, TOIE0_BIT, OCIE0_BIT.
- One sub-module, timer0_flag_bit, is instantiated twice. It is a single flag cell with inputs set, clr_w1, ack and outputs the flag, and it implements the priority above.

## Test plan
- Reset, then read TIFR -> io_rvalid=1 one cycle later with io_rdata=8'h00; irq_tov=irq_ocf=0.
- Pulse tov_evt, write TIMSK=8'h01 -> irq_tov=1. Read TIFR -> 8'h01. Write TIFR=8'h01 -> TOV0=0, irq_tov=0.
- Same cycle: tov_evt=1 and write TIFR=8'h01 -> TOV0 stays 1.
- With the macro defined, set OCF0 and OCIE0, pulse irq_ack_ocf -> OCF0=0 next cycle. Without the macro -> OCF0 stays 1.
- tcnt_in=8'hA5, read TCNT_ADDR -> io_rdata=8'hA5, io_rvalid=1. Read address 6'h10 -> io_rdata=0, io_rvalid=0.
- io_rd issued, then clr asserted the next cycle -> io_rvalid=0 and io_rdata=0; TIMSK and flags return to 0.

Source files
------------

// File: rtl/timer0_pkg.sv
// Shared Timer0 constants: default I/O addresses, TIFR/TIMSK bit positions
// and the read-address decoder.
package timer0_pkg;

   localparam logic [5:0] TCNT_ADDR_DEFAULT  = 6'h32;
   localparam logic [5:0] TCCR_ADDR_DEFAULT  = 6'h33;
   localparam logic [5:0] TIFR_ADDR_DEFAULT  = 6'h38;
   localparam logic [5:0] TIMSK_ADDR_DEFAULT = 6'h39;
   localparam logic [5:0] OCR_ADDR_DEFAULT   = 6'h3C;

   localparam int TOV0_BIT  = 0;
   localparam int OCF0_BIT  = 1;
   localparam int TOIE0_BIT = 0;
   localparam int OCIE0_BIT = 1;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_TCNT,
      SEL_TCCR,
      SEL_TIFR,
      SEL_TIMSK,
      SEL_OCR
   } rd_sel_e;

   // First match wins if two address parameters are ever set equal.
   function automatic rd_sel_e decode_addr(
      input logic [5:0] addr,
      input logic [5:0] tcnt_a,
      input logic [5:0] tccr_a,
      input logic [5:0] tifr_a,
      input logic [5:0] timsk_a,
      input logic [5:0] ocr_a
   );
      rd_sel_e sel;
      sel = SEL_NONE;
      if (addr == tcnt_a)       sel = SEL_TCNT;
      else if (addr == tccr_a)  sel = SEL_TCCR;
      else if (addr == tifr_a)  sel = SEL_TIFR;
      else if (addr == timsk_a) sel = SEL_TIMSK;
      else if (addr == ocr_a)   sel = SEL_OCR;
      return sel;
   endfunction

endpackage

// File: rtl/timer0_flag_bit.sv
// Single interrupt flag cell: reset > event set > clear (write-one or ack) > hold.
// The ack clear path exists only when TIMER0_IRQ_ACK_CLR_EN is defined.
module timer0_flag_bit (
   input  logic clk,
   input  logic clr,
   input  logic set,
   input  logic clr_w1,
   input  logic ack,
   output logic flag
);

   logic r_flag;
   logic w_clear;

`ifdef TIMER0_IRQ_ACK_CLR_EN
   assign w_clear = clr_w1 | ack;
`else
   logic w_unused_ack;
   assign w_unused_ack = ack;
   assign w_clear      = clr_w1;
`endif

   // An event arriving with a clear keeps the flag set so no event is lost.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_flag <= 1'b0;
      end else if (set) begin
         r_flag <= 1'b1;
      end else if (w_clear) begin
         r_flag <= 1'b0;
      end
   end

   assign flag = r_flag;

endmodule

// File: rtl/timer0_io_read_port.sv
// Timer0 CPU register port: owns TIFR/TIMSK, raises irqs, returns 1-cycle registered reads.
// Optional macro TIMER0_IRQ_ACK_CLR_EN lets irq_ack_* clear their flags.
module timer0_io_read_port
   import timer0_pkg::*;
#(
   parameter logic [5:0] TCNT_ADDR  = TCNT_ADDR_DEFAULT,
   parameter logic [5:0] TCCR_ADDR  = TCCR_ADDR_DEFAULT,
   parameter logic [5:0] TIFR_ADDR  = TIFR_ADDR_DEFAULT,
   parameter logic [5:0] TIMSK_ADDR = TIMSK_ADDR_DEFAULT,
   parameter logic [5:0] OCR_ADDR   = OCR_ADDR_DEFAULT
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [5:0] io_addr,
   input  logic       io_rd,
   input  logic       io_wr,
   input  logic [7:0] io_wdata,
   output logic [7:0] io_rdata,
   output logic       io_rvalid,
   input  logic [7:0] tcnt_in,
   input  logic [7:0] ocr_in,
   input  logic [7:0] tccr_in,
   input  logic       tov_evt,
   input  logic       ocf_evt,
   input  logic       irq_ack_tov,
   input  logic       irq_ack_ocf,
   output logic       irq_tov,
   output logic       irq_ocf
);

   logic       r_toie;
   logic       r_ocie;
   logic [7:0] r_rdata;
   logic       r_rvalid;

   logic       w_tov;
   logic       w_ocf;
   logic       w_tifr_wr;
   logic       w_timsk_wr;
   logic       w_tov_w1c;
   logic       w_ocf_w1c;
   rd_sel_e    w_rd_sel;
   logic       w_rd_hit;
   logic [7:0] w_rd_data;
   logic [7:0] w_tifr;
   logic [7:0] w_timsk;
   logic [5:0] w_unused_wdata;

   assign w_tifr_wr  = io_wr && (io_addr == TIFR_ADDR);
   assign w_timsk_wr = io_wr && (io_addr == TIMSK_ADDR);
   assign w_tov_w1c  = w_tifr_wr && io_wdata[TOV0_BIT];
   assign w_ocf_w1c  = w_tifr_wr && io_wdata[OCF0_BIT];

   assign w_unused_wdata = io_wdata[7:2];

   timer0_flag_bit u_tov_flag (
      .clk    (clk),
      .clr    (clr),
      .set    (tov_evt),
      .clr_w1 (w_tov_w1c),
      .ack    (irq_ack_tov),
      .flag   (w_tov)
   );

   timer0_flag_bit u_ocf_flag (
      .clk    (clk),
      .clr    (clr),
      .set    (ocf_evt),
      .clr_w1 (w_ocf_w1c),
      .ack    (irq_ack_ocf),
      .flag   (w_ocf)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         r_toie <= 1'b0;
         r_ocie <= 1'b0;
      end else if (w_timsk_wr) begin
         r_toie <= io_wdata[TOIE0_BIT];
         r_ocie <= io_wdata[OCIE0_BIT];
      end
   end

   assign irq_tov = w_tov & r_toie;
   assign irq_ocf = w_ocf & r_ocie;

   always_comb begin
      w_tifr            = 8'h00;
      w_tifr[TOV0_BIT]  = w_tov;
      w_tifr[OCF0_BIT]  = w_ocf;
      w_timsk           = 8'h00;
      w_timsk[TOIE0_BIT] = r_toie;
      w_timsk[OCIE0_BIT] = r_ocie;
   end

   assign w_rd_sel = decode_addr(io_addr, TCNT_ADDR, TCCR_ADDR, TIFR_ADDR,
                                 TIMSK_ADDR, OCR_ADDR);
   assign w_rd_hit = (w_rd_sel != SEL_NONE);

   // Reads sample pre-update state, so a same-cycle write/event is not visible.
   always_comb begin
      w_rd_data = 8'h00;
      case (w_rd_sel)
         SEL_TCNT:  w_rd_data = tcnt_in;
         SEL_TCCR:  w_rd_data = tccr_in;
         SEL_TIFR:  w_rd_data = w_tifr;
         SEL_TIMSK: w_rd_data = w_timsk;
         SEL_OCR:   w_rd_data = ocr_in;
         default:   w_rd_data = 8'h00;
      endcase
   end

   // Idle cycles drive zero so several ports can be OR-combined on the bus.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 8'h00;
      end else if (io_rd && w_rd_hit) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_data;
      end else begin
         r_rvalid <= 1'b0;
         r_rdata  <= 8'h00;
      end
   end

   assign io_rdata  = r_rdata;
   assign io_rvalid = r_rvalid;

endmodule

// File: tb/tb_timer0_io_read_port.sv
// Randomized scoreboard bench for timer0_io_read_port against a register-level model.
module tb_timer0_io_read_port;

   localparam logic [5:0] A_TCNT  = 6'h32;
   localparam logic [5:0] A_TCCR  = 6'h33;
   localparam logic [5:0] A_TIFR  = 6'h38;
   localparam logic [5:0] A_TIMSK = 6'h39;
   localparam logic [5:0] A_OCR   = 6'h3C;
`ifdef TIMER0_IRQ_ACK_CLR_EN
   localparam bit ACK_EN = 1'b1;
`else
   localparam bit ACK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [5:0] io_addr = '0;
   logic       io_rd = 1'b0;
   logic       io_wr = 1'b0;
   logic [7:0] io_wdata = '0;
   logic [7:0] io_rdata;
   logic       io_rvalid;
   logic [7:0] tcnt_in = '0;
   logic [7:0] ocr_in = '0;
   logic [7:0] tccr_in = '0;
   logic       tov_evt = 1'b0;
   logic       ocf_evt = 1'b0;
   logic       irq_ack_tov = 1'b0;
   logic       irq_ack_ocf = 1'b0;
   logic       irq_tov;
   logic       irq_ocf;

   always #5 clk = ~clk;

   timer0_io_read_port dut (
      .clk         (clk),
      .clr         (clr),
      .io_addr     (io_addr),
      .io_rd       (io_rd),
      .io_wr       (io_wr),
      .io_wdata    (io_wdata),
      .io_rdata    (io_rdata),
      .io_rvalid   (io_rvalid),
      .tcnt_in     (tcnt_in),
      .ocr_in      (ocr_in),
      .tccr_in     (tccr_in),
      .tov_evt     (tov_evt),
      .ocf_evt     (ocf_evt),
      .irq_ack_tov (irq_ack_tov),
      .irq_ack_ocf (irq_ack_ocf),
      .irq_tov     (irq_tov),
      .irq_ocf     (irq_ocf)
   );

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;

   // Register-level model: the four architectural bits
   bit m_tov, m_ocf, m_toie, m_ocie;

   function automatic bit model_hit(input logic [5:0] a);
      return (a == A_TCNT) || (a == A_TCCR) || (a == A_TIFR) ||
             (a == A_TIMSK) || (a == A_OCR);
   endfunction

   function automatic logic [7:0] model_read(input logic [5:0] a);
      case (a)
         A_TCNT:  return tcnt_in;
         A_TCCR:  return tccr_in;
         A_TIFR:  return {6'b0, m_ocf, m_tov};
         A_TIMSK: return {6'b0, m_ocie, m_toie};
         A_OCR:   return ocr_in;
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Applies current inputs for one clock, updates the model, checks irqs, then idles strobes.
   task automatic step();
      bit n_tov, n_ocf, n_toie, n_ocie, tifr_wr;
      if (io_rd && !clr && model_hit(io_addr))
         sb_q.push_back('{cyc + 1, model_read(io_addr)});
      tifr_wr = io_wr && (io_addr == A_TIFR);
      n_tov = m_tov; n_ocf = m_ocf; n_toie = m_toie; n_ocie = m_ocie;
      if (clr) begin
         n_tov = 0; n_ocf = 0; n_toie = 0; n_ocie = 0;
      end else begin
         if (tov_evt) n_tov = 1;
         else if ((tifr_wr && io_wdata[0]) || (ACK_EN && irq_ack_tov)) n_tov = 0;
         if (ocf_evt) n_ocf = 1;
         else if ((tifr_wr && io_wdata[1]) || (ACK_EN && irq_ack_ocf)) n_ocf = 0;
         if (io_wr && io_addr == A_TIMSK) begin
            n_toie = io_wdata[0];
            n_ocie = io_wdata[1];
         end
      end
      @(posedge clk);
      cyc++;
      m_tov = n_tov; m_ocf = n_ocf; m_toie = n_toie; m_ocie = n_ocie;
      #1;
      if (mon_en) begin
         chk8("irq_tov", {7'b0, irq_tov}, {7'b0, m_tov & m_toie});
         chk8("irq_ocf", {7'b0, irq_ocf}, {7'b0, m_ocf & m_ocie});
      end
      io_rd = 0; io_wr = 0; tov_evt = 0; ocf_evt = 0;
      irq_ack_tov = 0; irq_ack_ocf = 0; clr = 0;
   endtask

   task automatic do_read(input logic [5:0] a);
      io_rd = 1; io_addr = a;
      step();
   endtask

   task automatic do_write(input logic [5:0] a, input logic [7:0] d);
      io_wr = 1; io_addr = a; io_wdata = d;
      step();
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents read data
   always @(negedge clk) begin
      if (mon_en) begin
         if (io_rvalid) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rvalid: got rvalid=1 data=%h expected no read (cycle %0d)", io_rdata, cyc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               checks++;
               if (e.cyc != cyc) begin
                  errors++;
                  $display("FAIL rd_latency: got cycle %0d expected cycle %0d", cyc, e.cyc);
               end
               chk8("rdata", io_rdata, e.data);
            end
         end else begin
            if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
               checks++; errors++;
               $display("FAIL missing_rvalid: got rvalid=0 expected rvalid=1 data=%h (cycle %0d)", sb_q[0].data, cyc);
               void'(sb_q.pop_front());
            end
            chk8("idle_rdata", io_rdata, 8'h00);
         end
      end
   end

   initial begin
      // Reset and read TIFR
      clr = 1; step();
      clr = 1; step();
      mon_en = 1;
      chk8("rst_rvalid", {7'b0, io_rvalid}, 8'h00);
      chk8("rst_irq", {6'b0, irq_ocf, irq_tov}, 8'h00);
      do_read(A_TIFR);
      chk8("rst_tifr_rvalid", {7'b0, io_rvalid}, 8'h01);
      chk8("rst_tifr_data", io_rdata, 8'h00);

      // Overflow event, enable, read, write-one clear
      tov_evt = 1; step();
      do_write(A_TIMSK, 8'h01);
      chk8("irq_tov_set", {7'b0, irq_tov}, 8'h01);
      do_read(A_TIFR);
      chk8("tifr_tov", io_rdata, 8'h01);
      do_write(A_TIFR, 8'h01);
      chk8("irq_tov_clr", {7'b0, irq_tov}, 8'h00);

      // Event beats simultaneous write-one clear
      tov_evt = 1; io_wr = 1; io_addr = A_TIFR; io_wdata = 8'h01; step();
      chk8("evt_wins_irq", {7'b0, irq_tov}, 8'h01);
      do_read(A_TIFR);
      chk8("evt_wins_tifr", io_rdata, 8'h01);
      do_write(A_TIFR, 8'h01);

      // Compare flag and acknowledge
      ocf_evt = 1; step();
      do_write(A_TIMSK, 8'hFE);
      chk8("irq_ocf_set", {7'b0, irq_ocf}, 8'h01);
      irq_ack_ocf = 1; step();
      chk8("ack_ocf", {7'b0, irq_ocf}, ACK_EN ? 8'h00 : 8'h01);
      do_read(A_TIMSK);
      chk8("timsk_masked", io_rdata, 8'h02);

      // Pass-through read and unmapped address
      tcnt_in = 8'hA5;
      do_read(A_TCNT);
      chk8("tcnt_rdata", io_rdata, 8'hA5);
      chk8("tcnt_rvalid", {7'b0, io_rvalid}, 8'h01);
      do_read(6'h10);
      chk8("unmapped_rvalid", {7'b0, io_rvalid}, 8'h00);
      chk8("unmapped_rdata", io_rdata, 8'h00);

      // Read followed by reset, then read coincident with reset
      ocf_evt = 1; step();
      do_read(A_TIFR);
      clr = 1; step();
      chk8("post_clr_rvalid", {7'b0, io_rvalid}, 8'h00);
      chk8("post_clr_irq", {6'b0, irq_ocf, irq_tov}, 8'h00);
      io_rd = 1; io_addr = A_TCNT; clr = 1; step();
      chk8("rd_dropped_rvalid", {7'b0, io_rvalid}, 8'h00);
      chk8("rd_dropped_rdata", io_rdata, 8'h00);
      do_read(A_TIMSK);
      chk8("timsk_after_clr", io_rdata, 8'h00);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] addrs [0:5];
         addrs[0] = A_TCNT; addrs[1] = A_TCCR; addrs[2] = A_TIFR;
         addrs[3] = A_TIMSK; addrs[4] = A_OCR; addrs[5] = 6'($urandom);
         io_addr     = addrs[$urandom_range(0, 5)];
         io_rd       = ($urandom_range(0, 99) < 50);
         io_wr       = ($urandom_range(0, 99) < 30);
         io_wdata    = 8'($urandom);
         tcnt_in     = 8'($urandom);
         ocr_in      = 8'($urandom);
         tccr_in     = 8'($urandom);
         tov_evt     = ($urandom_range(0, 99) < 20);
         ocf_evt     = ($urandom_range(0, 99) < 20);
         irq_ack_tov = ($urandom_range(0, 99) < 20);
         irq_ack_ocf = ($urandom_range(0, 99) < 20);
         clr         = ($urandom_range(0, 99) < 2);
         step();
      end

      step();
      step();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending reads expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
